// File: rtl/sop_pos_sweep.sv
// Walks every row of an N-input truth table, comparing a SoP mask against a PoS mask.
// Latency: row i on the outputs i+1 cycles after start is accepted; done one cycle after the last row.
// Backpressure: none; a start seen while busy is dropped, never queued.
module sop_pos_sweep #(
    parameter int N = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2**N-1:0]   minterms,
    input  logic [2**N-1:0]   maxterms,
    output logic              busy,
    output logic              valid,
    output logic [N-1:0]      x_vec,
    output logic              sop_s,
    output logic              pos_s,
    output logic              done,
    output logic              equal,
    output logic [N:0]        mismatch_cnt,
    output logic [N-1:0]      first_bad
);

    localparam int          ROWS    = 2**N;
    localparam logic [N-1:0] LAST   = {N{1'b1}};
    localparam logic [N-1:0] IDX_ONE = 1;
    localparam logic [N:0]   CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t          state;
    logic [ROWS-1:0] min_q;
    logic [ROWS-1:0] max_q;
    logic            row_bad;
    logic [N:0]      cnt_next;
    logic [N-1:0]    next_idx;

    // Mismatches are counted from the registered row, so the count trails the row by one edge.
    assign row_bad  = valid && (sop_s != pos_s);
    assign cnt_next = row_bad ? mismatch_cnt + CNT_ONE : mismatch_cnt;
    assign next_idx = x_vec + IDX_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            min_q        <= '0;
            max_q        <= '0;
            busy         <= 1'b0;
            valid        <= 1'b0;
            x_vec        <= '0;
            sop_s        <= 1'b0;
            pos_s        <= 1'b0;
            done         <= 1'b0;
            equal        <= 1'b0;
            mismatch_cnt <= '0;
            first_bad    <= '0;
        end else begin
            done         <= 1'b0;
            mismatch_cnt <= cnt_next;
            if (row_bad && mismatch_cnt == '0)
                first_bad <= x_vec;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Row 0 is evaluated straight from the inputs being latched.
                        state        <= SWEEP;
                        busy         <= 1'b1;
                        min_q        <= minterms;
                        max_q        <= maxterms;
                        valid        <= 1'b1;
                        x_vec        <= '0;
                        sop_s        <= minterms[0];
                        pos_s        <= ~maxterms[0];
                        mismatch_cnt <= '0;
                        first_bad    <= '0;
                    end
                end
                SWEEP: begin
                    if (x_vec == LAST) begin
                        state <= DONE;
                        valid <= 1'b0;
                        x_vec <= '0;
                        sop_s <= 1'b0;
                        pos_s <= 1'b0;
                        done  <= 1'b1;
                        equal <= (cnt_next == '0);
                    end else begin
                        x_vec <= next_idx;
                        sop_s <= min_q[next_idx];
                        pos_s <= ~max_q[next_idx];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
